// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: walks pwm duty toward a CPU-programmed target over an Avalon-MM master.
// Optional feature macro: PWM_RAMP_IRQ_EN (adds irq output and CTRL/STATUS bit3 irq_en).
module pwm_ramp_ctrl #(
  parameter int CNT_W            = 24,
  parameter int DUTY_MAX         = 100,
  parameter int DEFAULT_STEP     = 10,
  parameter int DEFAULT_INTERVAL = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write,
  output logic [31:0]      m_writedata,
  input  logic             m_waitrequest
`ifdef PWM_RAMP_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [6:0]       DUTY_MAX_C = 7'(DUTY_MAX);
  localparam logic [6:0]       DEF_STEP_C = 7'(DEFAULT_STEP);
  localparam logic [CNT_W-1:0] DEF_INTV_C = CNT_W'(DEFAULT_INTERVAL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [6:0] sat_target(input logic [31:0] v);
    return (v > 32'(DUTY_MAX)) ? DUTY_MAX_C : v[6:0];
  endfunction

  function automatic logic [6:0] nz_step(input logic [6:0] v);
    return (v == 7'd0) ? 7'd1 : v;
  endfunction

  function automatic logic [CNT_W-1:0] nz_intv(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // One step toward tgt, limited to the remaining distance so the target is never overshot.
  function automatic logic [6:0] step_toward(input logic [6:0] cur,
                                             input logic [6:0] tgt,
                                             input logic [6:0] step);
    logic [6:0] diff;
    logic [6:0] dlt;
    diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    dlt  = (step < diff) ? step : diff;
    return (tgt >= cur) ? (cur + dlt) : (cur - dlt);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       target_q, step_q;
  logic [CNT_W-1:0] interval_q;
  logic [6:0]       tgt_w_q, step_w_q;
  logic [CNT_W-1:0] intv_w_q;
  logic [6:0]       next_q;
  logic [6:0]       cur_duty_q;
  logic             done_q;
  logic             abort_pend_q;
  logic             irq_en_bit;
  logic             busy;
  logic             wr_en, ctrl_wr, start_req, abort_req, clr_req, accepted;

  assign wr_en     = chipselect && write;
  assign ctrl_wr   = wr_en && (address == 2'd3);
  assign abort_req = ctrl_wr && writedata[1];
  assign start_req = ctrl_wr && writedata[0] && !writedata[1];
  assign clr_req   = ctrl_wr && writedata[2];
  assign accepted  = (state_q == S_WRITE) && !m_waitrequest;
  assign busy      = (state_q != S_IDLE);

`ifdef PWM_RAMP_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en_q <= writedata[3];
    end
  end

  assign irq_en_bit = irq_en_q;
  assign irq        = done_q && irq_en_q;
`else
  assign irq_en_bit = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (target_q == cur_duty_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = interval_q - CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (!m_waitrequest) begin
          if (abort_pend_q || abort_req) begin
            state_d = S_IDLE;
          end else if (next_q == tgt_w_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = intv_w_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    m_address    = 2'b00;
    m_write      = (state_q == S_WRITE);
    m_chipselect = m_write;
    m_writedata  = m_write ? 32'(next_q) : 32'd0;
  end

  // ---- programmable registers, done flag and duty tracking ----
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q     <= 7'd0;
      step_q       <= DEF_STEP_C;
      interval_q   <= DEF_INTV_C;
      cur_duty_q   <= 7'd0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      if (wr_en) begin
        case (address)
          2'd0:    target_q   <= sat_target(writedata);
          2'd1:    step_q     <= nz_step(writedata[6:0]);
          2'd2:    interval_q <= nz_intv(writedata[CNT_W-1:0]);
          default: ;
        endcase
      end
      if (accepted) begin
        cur_duty_q <= next_q;
      end
      // Completion beats a simultaneous clear.
      if (state_q == S_DONE) begin
        done_q <= 1'b1;
      end else if (clr_req) begin
        done_q <= 1'b0;
      end
      // An abort arriving while the master is stalled is remembered until the transfer lands.
      if ((state_q == S_WRITE) && m_waitrequest) begin
        abort_pend_q <= abort_pend_q || abort_req;
      end else begin
        abort_pend_q <= 1'b0;
      end
    end
  end

  // ---- working copies and step computation (data only, no reset) ----
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && start_req) begin
      tgt_w_q  <= target_q;
      step_w_q <= step_q;
      intv_w_q <= interval_q;
    end
    if ((state_q == S_WAIT) && (cnt_q == '0)) begin
      next_q <= step_toward(cur_duty_q, tgt_w_q, step_w_q);
    end
  end

  // ---- slave read port ----
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (chipselect && read) begin
      case (address)
        2'd0:    readdata <= 32'(target_q);
        2'd1:    readdata <= 32'(step_q);
        2'd2:    readdata <= 32'(interval_q);
        default: readdata <= 32'({cur_duty_q, 4'b0000, irq_en_bit, 1'b0, done_q, busy});
      endcase
    end else begin
      readdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized self-checking bench for pwm_ramp_ctrl with a ramp-sequence scoreboard.
module tb_pwm_ramp_ctrl;

  localparam int DUTY_MAX = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
`ifdef PWM_RAMP_IRQ_EN
  logic        irq;
`endif

  pwm_ramp_ctrl #(
    .CNT_W(24), .DUTY_MAX(DUTY_MAX), .DEFAULT_STEP(10), .DEFAULT_INTERVAL(50000)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
`ifdef PWM_RAMP_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_cur   = 0;
  int unsigned ctl_keep = 0;
  int unsigned acc_d[$];
  int          acc_c[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard capture of every accepted master transfer.
  always @(negedge clk) begin
    if (m_write) begin
      chk("m_cs_eq_write", {31'd0, m_chipselect}, 32'd1);
      chk("m_address", {30'd0, m_address}, 32'd0);
      if (!m_waitrequest) begin
        acc_d.push_back(m_writedata);
        acc_c.push_back(cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // Program a ramp, start it, and compare the observed writes with the expected duty sequence.
  task automatic run_ramp(input int unsigned t_raw, input int unsigned s_raw,
                          input int unsigned i_raw, input bit poke);
    int tgt, st, iv, c, d, start_cyc;
    int exp_q[$];
    logic [31:0] r;
    tgt = (t_raw > DUTY_MAX) ? DUTY_MAX : int'(t_raw);
    st  = ((s_raw & 127) == 0) ? 1 : int'(s_raw & 127);
    iv  = (i_raw == 0) ? 1 : int'(i_raw);
    c = m_cur;
    while (c != tgt) begin
      d = (tgt > c) ? tgt - c : c - tgt;
      if (d > st) d = st;
      c = (tgt > c) ? c + d : c - d;
      exp_q.push_back(c);
    end
    bus_write(2'd3, 32'd4 | ctl_keep);
    bus_write(2'd0, t_raw);
    bus_write(2'd1, s_raw);
    bus_write(2'd2, i_raw);
    acc_d.delete(); acc_c.delete();
    start_cyc = cyc;
    bus_write(2'd3, 32'd1 | ctl_keep);
    if (poke && exp_q.size() > 0) begin
      bus_write(2'd0, 32'd5);
      bus_write(2'd3, 32'd1 | ctl_keep);
    end
    wait_cyc((exp_q.size() + 1) * (iv + 1) + 4);
    chk("ramp_nwrites", acc_d.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < acc_d.size(); k++) begin
      chk("ramp_duty", acc_d[k], exp_q[k]);
      chk("ramp_time", acc_c[k], start_cyc + (k + 1) * (iv + 1));
    end
    m_cur = tgt;
    bus_read(2'd3, r);
    chk("ramp_status", r, (tgt << 8) | 2 | ctl_keep);
  endtask

  initial begin
    logic [31:0] r;
    bit seen;
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = 32'd0; m_waitrequest = 1'b0;

    // T1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_m_write", {31'd0, m_write}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus_read(2'd3, r); chk("rst_status", r, 32'd0);
    bus_read(2'd1, r); chk("rst_step", r, 32'd10);
    bus_read(2'd2, r); chk("rst_interval", r, 32'd50000);
    bus_read(2'd0, r); chk("rst_target", r, 32'd0);

    // Register write clamping
    bus_write(2'd1, 32'd0);   bus_read(2'd1, r); chk("step_zero", r, 32'd1);
    bus_write(2'd2, 32'd0);   bus_read(2'd2, r); chk("intv_zero", r, 32'd1);
    bus_write(2'd0, 32'd200); bus_read(2'd0, r); chk("target_clamp", r, 32'd100);
    bus_write(2'd0, 32'd77);  bus_read(2'd0, r); chk("target_plain", r, 32'd77);

    // T2 / T3: directed ramps
    run_ramp(30, 10, 4, 0);
    run_ramp(0, 25, 4, 0);
    run_ramp(200, 30, 3, 0);

    // T4: stalled transfer from 100 down to 90
    m_waitrequest = 1'b1;
    bus_write(2'd0, 32'd90); bus_write(2'd1, 32'd10); bus_write(2'd2, 32'd2);
    acc_d.delete(); acc_c.delete();
    bus_write(2'd3, 32'd1 | ctl_keep);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = m_write;
    end
    chk("wr_seen", {31'd0, seen}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_m_write", {31'd0, m_write}, 32'd1);
      chk("stall_data", m_writedata, 32'd90);
    end
    bus_read(2'd3, r); chk("stall_cur_duty", (r >> 8) & 32'h7f, 32'd100);
    m_waitrequest = 1'b0;
    wait_cyc(4);
    chk("stall_nacc", acc_d.size(), 32'd1);
    if (acc_d.size() > 0) chk("stall_acc_data", acc_d[0], 32'd90);
    bus_read(2'd3, r); chk("stall_status", r, (90 << 8) | 2 | ctl_keep);
    m_cur = 90;

    // T5: abort during WAIT
    bus_write(2'd3, 32'd4 | ctl_keep);
    bus_write(2'd0, 32'd0); bus_write(2'd1, 32'd10); bus_write(2'd2, 32'd20);
    acc_d.delete(); acc_c.delete();
    bus_write(2'd3, 32'd1 | ctl_keep);
    wait_cyc(5);
    bus_write(2'd3, 32'd2 | ctl_keep);
    wait_cyc(2);
    bus_read(2'd3, r); chk("abort_status", r, (90 << 8) | ctl_keep);
    wait_cyc(30);
    chk("abort_nwrites", acc_d.size(), 32'd0);

    // Start while busy is ignored; abort+start together never starts
    run_ramp(60, 15, 3, 1);
    acc_d.delete(); acc_c.delete();
    bus_write(2'd3, 32'd3 | ctl_keep);
    wait_cyc(10);
    chk("abort_start_nwrites", acc_d.size(), 32'd0);
    bus_read(2'd3, r); chk("abort_start_status", r, (60 << 8) | 2 | ctl_keep);
    // Target equals current duty: done without a write
    run_ramp(60, 5, 3, 0);

`ifdef PWM_RAMP_IRQ_EN
    ctl_keep = 8;
    bus_write(2'd3, 32'd12);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    run_ramp(80, 10, 2, 0);
    chk("irq_set", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'd12);
    chk("irq_clear_after", {31'd0, irq}, 32'd0);
`else
    bus_write(2'd3, 32'd8);
    bus_read(2'd3, r); chk("bit3_ignored", r & 32'd8, 32'd0);
`endif

    // Randomized ramps
    for (int n = 0; n < 12; n++) begin
      int unsigned t, s, iv;
      t  = ($urandom_range(0, 5) == 0) ? $urandom_range(101, 1000) : $urandom_range(0, 100);
      s  = $urandom_range(0, 40);
      iv = $urandom_range(0, 5);
      run_ramp(t, s, iv, bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a ramp
    bus_write(2'd0, (m_cur > 50) ? 32'd0 : 32'd100);
    bus_write(2'd1, 32'd5); bus_write(2'd2, 32'd1);
    bus_write(2'd3, 32'd1 | ctl_keep);
    wait_cyc(9);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    chk("midrst_m_write", {31'd0, m_write}, 32'd0);
    bus_read(2'd3, r); chk("midrst_status", r, 32'd0);
    bus_read(2'd1, r); chk("midrst_step", r, 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
